ram_bank_clr: RTL and testbench

- Parametrised single-port synchronous RAM bank for the Hack memory hierarchy; the next generation of the fixed 4096x16 RAM.
- Generalised width and depth. Adds an explicit access enable and a registered read-valid strobe.
- Adds a hardware clear sequencer that zero-fills (or pattern-fills) the array after reset or on request, with a busy flag.
- Sits under the data-memory map; instances of different depths replace the fixed-size RAM blocks.

---
 rtl/ram_bank_clr.sv | 186 ++++++++++++++++++
 tb/tb_ram_bank_clr.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bank_clr.sv
// ram_bank_clr -- parametrised single-port synchronous RAM bank with a
// hardware clear sequencer.
//
// After reset, or on a clear request, the bank walks every address and
// writes CLEAR_VALUE into it. busy is high while this runs. Normal accesses
// are accepted only once the walk has finished.
//
// Optional build macro: RAM_BANK_PARITY_EN
//   When defined, each word also stores an even-parity bit. An in-range read
//   reports a stored-parity mismatch on parity_err. When undefined,
//   parity_err is tied low. The port list is the same in both builds.
//
// Ports:
//   clk         in   rising-edge clock, sole clock domain
//   rst_n       in   asynchronous active-low reset
//   in          in   [WIDTH]  write data
//   load        in   write select when en=1 (1=write, 0=read)
//   en          in   access strobe, sampled only in READY
//   address     in   [ADDR_W] word address
//   clear       in   full-array clear request, sampled only in READY
//   out         out  [WIDTH]  registered read data / write-through data
//   out_valid   out  one-cycle pulse marking an accepted access result
//   busy        out  high while the clear sequencer runs
//   parity_err  out  read parity mismatch (parity build only, else 0)
//
// Handshake: there is no back-pressure. An access is accepted on any rising
// edge where the FSM is in READY, en=1 and clear=0. Its result appears on out
// after that same edge, with out_valid=1 for exactly one cycle. With en=0,
// out holds its value and out_valid=0.
//
// Debug: the FSM state is kept in the signal `state` (ST_CLEAR / ST_READY).
// It can be probed hierarchically.

module ram_bank_clr #(
   parameter int               WIDTH       = 16,
   parameter int               DEPTH       = 4096,
   parameter int               ADDR_W      = 12,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic              en,
   input  logic [ADDR_W-1:0] address,
   input  logic              clear,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic              busy,
   output logic              parity_err
);

   // Array index width. Addresses at or above DEPTH are filtered out by
   // in_range before the index is used to write.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // DEPTH is compared one bit wider than the address. This lets
   // DEPTH == 2^ADDR_W be represented.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;

   logic [WIDTH-1:0]  mem [DEPTH];

   logic              in_range;
   logic              accept;
   logic [IDX_W-1:0]  acc_idx;
   logic [IDX_W-1:0]  clr_idx;
   logic [WIDTH-1:0]  rd_data;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [WIDTH-1:0]  wr_data;

   assign in_range = ({1'b0, address} < DEPTH_EXT);
   assign acc_idx  = address[IDX_W-1:0];
   assign clr_idx  = cnt[IDX_W-1:0];
   assign rd_data  = mem[acc_idx];

   // A clear request outranks a simultaneous access.
   // The dropped access neither writes nor produces out_valid.
   assign accept   = (state == ST_READY) && en && !clear;

   // Single write port, shared by the clear sequencer and normal writes.
   // Out-of-range writes are discarded here.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = acc_idx;
      wr_data = in;
      if (state == ST_CLEAR) begin
         wr_en   = 1'b1;
         wr_idx  = clr_idx;
         wr_data = CLEAR_VALUE;
      end else if (accept && load && in_range) begin
         wr_en   = 1'b1;
      end
   end

   // Storage has no reset. The clear sequencer is what initialises it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Control FSM and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_CLEAR;
         cnt       <= '0;
         busy      <= 1'b1;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               // en, load and clear are all ignored while clearing.
               out_valid <= 1'b0;
               if (cnt == LAST_ADDR) begin
                  state <= ST_READY;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + ADDR_W'(1);
               end
            end
            ST_READY: begin
               if (clear) begin
                  state     <= ST_CLEAR;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  out_valid <= 1'b0;
               end else if (en) begin
                  out_valid <= 1'b1;
                  if (!in_range) begin
                     out <= '0;
                  end else if (load) begin
                     out <= in;
                  end else begin
                     out <= rd_data;
                  end
               end else begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_CLEAR;
               busy      <= 1'b1;
               cnt       <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef RAM_BANK_PARITY_EN
   // Even-parity side array. It is written in lockstep with the data array,
   // so the clear sequencer also stores the parity of CLEAR_VALUE.
   logic par_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         par_mem[wr_idx] <= ^wr_data;
      end
   end

   // parity_err is only set by an accepted in-range read. It is 0 on every
   // other edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= accept && !load && in_range &&
                       (par_mem[acc_idx] != ^rd_data);
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bank_clr.sv
// tb_ram_bank_clr -- self-checking bench for ram_bank_clr.
//
// Configuration: DEPTH=12, ADDR_W=4, CLEAR_VALUE=16'hA5A5. With these values,
// addresses 12..15 exist on the bus but are out of range.
//
// The stimulus process drives accesses. For each accepted access, it pushes
// the expected {parity_err, out} into exp_q, taken from a word-array model of
// the bank. A separate monitor pops and compares on every cycle where the DUT
// shows out_valid. Clear and reset timing are checked directly from busy.

module tb_ram_bank_clr;

   localparam int               WIDTH  = 16;
   localparam int               DEPTH  = 12;
   localparam int               ADDR_W = 4;
   localparam logic [WIDTH-1:0] CV     = 16'hA5A5;
   localparam int               SBW    = WIDTH + 1;
   localparam int               NADDR  = 1 << ADDR_W;

   logic              clk;
   logic              rst_n;
   logic [WIDTH-1:0]  in;
   logic              load;
   logic              en;
   logic [ADDR_W-1:0] address;
   logic              clear;
   logic [WIDTH-1:0]  out;
   logic              out_valid;
   logic              busy;
   logic              parity_err;

   ram_bank_clr #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .ADDR_W      (ADDR_W),
      .CLEAR_VALUE (CV)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in),
      .load       (load),
      .en         (en),
      .address    (address),
      .clear      (clear),
      .out        (out),
      .out_valid  (out_valid),
      .busy       (busy),
      .parity_err (parity_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int               n_tests = 0;
   int               n_fail  = 0;
   logic [SBW-1:0]   exp_q[$];
   logic [WIDTH-1:0] model_mem  [NADDR];
   bit               model_flip [NADDR];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every cell in range is overwritten by a completed clear.
   task automatic model_clear();
      for (int i = 0; i < NADDR; i++) begin
         model_mem[i]  = (i < DEPTH) ? CV : '0;
         model_flip[i] = 1'b0;
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [SBW-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("out", out, e[WIDTH-1:0]);
               check("parity_err", parity_err, e[WIDTH]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One accepted access. The expectation comes from the word-level model.
   task automatic access(input bit ld, input logic [ADDR_W-1:0] a,
                         input logic [WIDTH-1:0] d);
      logic [SBW-1:0] e;
      en      = 1'b1;
      load    = ld;
      address = a;
      in      = d;
      if (int'(a) >= DEPTH) begin
         e = '0;
      end else if (ld) begin
         model_mem[a]  = d;
         model_flip[a] = 1'b0;
         e = {1'b0, d};
      end else begin
         e = {model_flip[a], model_mem[a]};
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      en   = 1'b0;
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts edges until busy falls. clear is held high for the first `hold`
   // edges, which a running clear must ignore.
   task automatic wait_clear(input int hold, input string name);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (n < 200 && !done) begin
         clear = (n < hold);
         @(posedge clk);
         #1;
         n++;
         if (!busy) done = 1'b1;
      end
      clear = 1'b0;
      check(name, n, DEPTH);
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) begin
         access(1'b0, ADDR_W'(a), '0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n   = 1'b1;
      in      = '0;
      load    = 1'b0;
      en      = 1'b0;
      address = '0;
      clear   = 1'b0;
      model_clear();

      // Reset values, sampled while rst_n is low.
      #2 rst_n = 1'b0;
      #10;
      check("rst_out", out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_busy", busy, 1);

      // Release the reset. The clear must take exactly DEPTH edges.
      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_clear(0, "reset_clear_edges");
      model_clear();
      read_all();

      // Write-through, readback, and a neighbour still holding CLEAR_VALUE.
      access(1'b1, 4'd5, 16'h1234);
      access(1'b0, 4'd5, '0);
      access(1'b0, 4'd6, '0);

      // Read of an address written on the previous edge.
      access(1'b1, 4'd7, WIDTH'($urandom));
      access(1'b0, 4'd7, '0);

      // Out-of-range: the write is discarded and both accesses return 0.
      access(1'b1, 4'd13, 16'hBEEF);
      access(1'b0, 4'd13, '0);
      read_all();

      // Random back-to-back mix, including out-of-range addresses.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) != 0) begin
            access(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NADDR - 1)),
                   WIDTH'($urandom));
         end else begin
            idle(1);
         end
      end

      // Clear outranks a simultaneous write. Clear held during CLEAR is ignored.
      clear   = 1'b1;
      en      = 1'b1;
      load    = 1'b1;
      address = 4'd3;
      in      = 16'hFFFF;
      @(posedge clk);
      #1;
      en   = 1'b0;
      load = 1'b0;
      check("prio_busy", busy, 1);
      check("prio_out_valid", out_valid, 0);
      wait_clear(2, "clear_req_edges");
      model_clear();
      access(1'b0, 4'd3, '0);
      read_all();

      // Reset pulse at clear cycle 7 restarts a full clear.
      for (int a = 0; a < DEPTH; a++) begin
         access(1'b1, ADDR_W'(a), WIDTH'($urandom));
      end
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      idle(7);
      rst_n = 1'b0;
      #1;
      check("midclr_busy", busy, 1);
      check("midclr_out_valid", out_valid, 0);
      #2 rst_n = 1'b1;
      wait_clear(0, "reset_mid_clear_edges");
      model_clear();
      read_all();

`ifdef RAM_BANK_PARITY_EN
      // Corrupt one stored data bit behind the parity bit's back.
      access(1'b1, 4'd2, 16'h0001);
      idle(1);
      dut.mem[2] = dut.mem[2] ^ 16'h0001;
      model_mem[2]  = model_mem[2] ^ 16'h0001;
      model_flip[2] = 1'b1;
      access(1'b0, 4'd2, '0);
      access(1'b0, 4'd4, '0);
`endif

      idle(3);
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
